// File: rtl/axi_mem_tester_if.sv
// axi_mem_tester_if: AXI4 write/read channel bundle between the memory tester and its slave.
interface axi_mem_tester_if;
    logic [5:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [5:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [5:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );
    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_mem_tester.sv
// axi_mem_tester: writes num_bursts INCR bursts of address^seed, reads them back and counts mismatches.
module axi_mem_tester #(
    parameter logic [5:0] AXI_ID       = 6'h00,
    parameter int         MAX_BURSTS_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             base_addr,
    input  logic [MAX_BURSTS_W-1:0] num_bursts,
    input  logic [3:0]              beats_m1,
    input  logic [31:0]             seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_count,
    output logic [31:0]             first_err_addr,
    axi_mem_tester_if.master        m_axi
);
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FIN} state_t;
    localparam logic [MAX_BURSTS_W-1:0] ONE = 1;
    state_t                  state_q, state_d;
    logic [31:0]             base_q, base_d, addr_q, addr_d, seed_q, seed_d;
    logic [31:0]             ferr_q, ferr_d, wdata_q, wdata_d, beat_addr, err_at;
    logic [MAX_BURSTS_W-1:0] nb_q, nb_d, burst_q, burst_d;
    logic [3:0]              blen_q, blen_d, beat_q, beat_d;
    logic [15:0]             err_q, err_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
    logic                    bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    last_burst, last_beat, err_hit;

    always_comb begin
        beat_addr  = addr_q + {26'b0, beat_q, 2'b00};
        last_burst = burst_q + ONE == nb_q;
        last_beat  = beat_q == blen_q;
        state_d    = state_q;
        base_d     = base_q;
        addr_d     = addr_q;
        seed_d     = seed_q;
        nb_d       = nb_q;
        burst_d    = burst_q;
        blen_d     = blen_q;
        beat_d     = beat_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
        err_hit    = 1'b0;
        err_at     = addr_q;
        case (state_q)
            IDLE: if (start) begin
                base_d  = base_addr & 32'hFFFF_FFC0;
                addr_d  = base_addr & 32'hFFFF_FFC0;
                seed_d  = seed;
                nb_d    = num_bursts;
                blen_d  = beats_m1;
                burst_d = '0;
                beat_d  = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = '0;
                ferr_d  = '0;
                state_d = num_bursts != '0 ? AW : FIN;
            end
            AW: if (m_axi.awready) begin
                beat_d  = '0;
                state_d = W;
            end
            W: if (m_axi.wready) begin
                beat_d  = beat_q + 4'd1;
                state_d = last_beat ? B : W;
            end
            B: if (m_axi.bvalid) begin
                err_hit = m_axi.bresp != 2'b00 || m_axi.bid != AXI_ID;
                burst_d = last_burst ? '0 : burst_q + ONE;
                addr_d  = last_burst ? base_q : addr_q + 32'd64;
                state_d = last_burst ? AR : AW;
            end
            AR: if (m_axi.arready) begin
                beat_d  = '0;
                state_d = R;
            end
            R: if (m_axi.rvalid) begin
                // rlast is checked, not trusted: the burst always ends after beats_m1+1 beats
                err_hit = m_axi.rdata != (beat_addr ^ seed_q) || m_axi.rresp != 2'b00 ||
                          m_axi.rid != AXI_ID || m_axi.rlast != last_beat;
                err_at  = beat_addr;
                beat_d  = beat_q + 4'd1;
                if (last_beat) begin
                    burst_d = burst_q + ONE;
                    addr_d  = addr_q + 32'd64;
                    state_d = last_burst ? FIN : AR;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (err_hit) begin
            err_d  = err_q == 16'hFFFF ? err_q : err_q + 16'd1;
            ferr_d = err_q == 16'd0 ? err_at : ferr_q;
        end
        awvalid_d = state_d == AW;
        wvalid_d  = state_d == W;
        bready_d  = state_d == B;
        arvalid_d = state_d == AR;
        rready_d  = state_d == R;
        wlast_d   = state_d == W && beat_d == blen_d;
        wdata_d   = (addr_d + {26'b0, beat_d, 2'b00}) ^ seed_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            seed_q    <= '0;
            nb_q      <= '0;
            burst_q   <= '0;
            blen_q    <= '0;
            beat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            ferr_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            wdata_q   <= '0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            seed_q    <= seed_d;
            nb_q      <= nb_d;
            burst_q   <= burst_d;
            blen_q    <= blen_d;
            beat_q    <= beat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ferr_q    <= ferr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            wdata_q   <= wdata_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = done_q && err_q == 16'd0;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
    assign m_axi.awid     = AXI_ID;
    assign m_axi.awaddr   = addr_q;
    assign m_axi.awlen    = {4'b0, blen_q};
    assign m_axi.awsize   = 3'b010;
    assign m_axi.awburst  = 2'b01;
    assign m_axi.awvalid  = awvalid_q;
    assign m_axi.wdata    = wdata_q;
    assign m_axi.wstrb    = 4'hF;
    assign m_axi.wlast    = wlast_q;
    assign m_axi.wvalid   = wvalid_q;
    assign m_axi.bready   = bready_q;
    assign m_axi.arid     = AXI_ID;
    assign m_axi.araddr   = addr_q;
    assign m_axi.arlen    = {4'b0, blen_q};
    assign m_axi.arsize   = 3'b010;
    assign m_axi.arburst  = 2'b01;
    assign m_axi.arvalid  = arvalid_q;
    assign m_axi.rready   = rready_q;
endmodule

// File: tb/tb_axi_mem_tester.sv
// tb_axi_mem_tester: directed scenarios against a reactive AXI memory slave with fault injection.
module tb_axi_mem_tester;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] base_addr, seed, first_err_addr;
    logic [15:0] num_bursts, err_count;
    logic [3:0]  beats_m1;
    logic        busy, done, pass;
    int          checks = 0, errors = 0;

    axi_mem_tester_if m();

    axi_mem_tester dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .beats_m1(beats_m1), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .m_axi(m)
    );

    always #5 clk = ~clk;

    bit          bp = 1'b0, no_rlast = 1'b0;
    int          bad_b = -1;
    logic [31:0] bad_raddr = '1;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] aw_log [$];
    logic [31:0] ar_log [$];
    logic [7:0]  awlen_log [$];
    logic [7:0]  arlen_log [$];
    int          w_cnt = 0, b_cnt = 0;
    logic [31:0] waddr, raddr, ra;
    logic [7:0]  wbeat, rbeat, rlen;
    logic        b_pend, r_act;

    // memory slave: writes land in mem, reads return mem with optional faults
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m.awready <= 1'b0; m.wready <= 1'b0; m.arready <= 1'b0;
            m.bvalid <= 1'b0; m.bid <= '0; m.bresp <= '0;
            m.rvalid <= 1'b0; m.rid <= '0; m.rresp <= '0; m.rdata <= '0; m.rlast <= 1'b0;
            b_pend <= 1'b0; r_act <= 1'b0; wbeat <= '0; rbeat <= '0; rlen <= '0;
            waddr <= '0; raddr <= '0;
        end else begin
            m.awready <= !bp || $urandom_range(0, 1) == 1;
            m.wready  <= !bp || $urandom_range(0, 1) == 1;
            m.arready <= !bp || $urandom_range(0, 1) == 1;
            if (m.awvalid && m.awready) begin
                aw_log.push_back(m.awaddr);
                awlen_log.push_back(m.awlen);
                waddr <= m.awaddr;
                wbeat <= '0;
            end
            if (m.wvalid && m.wready) begin
                mem[waddr + 32'(wbeat) * 32'd4] = m.wdata;
                wbeat <= wbeat + 8'd1;
                w_cnt++;
                if (m.wlast) b_pend <= 1'b1;
            end
            if (m.bvalid && m.bready) m.bvalid <= 1'b0;
            else if (b_pend && !m.bvalid && (!bp || $urandom_range(0, 1) == 1)) begin
                m.bvalid <= 1'b1;
                m.bresp  <= b_cnt == bad_b ? 2'b10 : 2'b00;
                b_cnt++;
                b_pend   <= 1'b0;
            end
            if (m.arvalid && m.arready) begin
                ar_log.push_back(m.araddr);
                arlen_log.push_back(m.arlen);
                raddr <= m.araddr;
                rlen  <= m.arlen;
                rbeat <= '0;
                r_act <= 1'b1;
            end
            if (m.rvalid && m.rready) begin
                m.rvalid <= 1'b0;
                rbeat    <= rbeat + 8'd1;
                if (rbeat == rlen) r_act <= 1'b0;
            end else if (r_act && !m.rvalid && (!bp || $urandom_range(0, 1) == 1)) begin
                ra = raddr + 32'(rbeat) * 32'd4;
                m.rvalid <= 1'b1;
                m.rdata  <= mem[ra] ^ (ra == bad_raddr ? 32'h1 : 32'h0);
                m.rlast  <= !no_rlast && rbeat == rlen;
            end
        end
    end

    int          stab_err = 0, vld_cnt = 0, attr_err = 0;
    logic        p_aw, p_w, p_ar, p_wlast;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
        end else begin
            if (p_aw && (m.awvalid !== 1'b1 || m.awaddr !== p_awaddr)) stab_err++;
            if (p_w && (m.wvalid !== 1'b1 || m.wdata !== p_wdata || m.wlast !== p_wlast)) stab_err++;
            if (p_ar && (m.arvalid !== 1'b1 || m.araddr !== p_araddr)) stab_err++;
            if (m.awvalid || m.wvalid || m.arvalid) vld_cnt++;
            if (m.awvalid && (m.awid !== 6'h00 || m.awsize !== 3'b010 || m.awburst !== 2'b01)) attr_err++;
            if (m.arvalid && (m.arid !== 6'h00 || m.arsize !== 3'b010 || m.arburst !== 2'b01)) attr_err++;
            if (m.wvalid && m.wstrb !== 4'hF) attr_err++;
            p_aw <= m.awvalid && !m.awready; p_awaddr <= m.awaddr;
            p_w  <= m.wvalid && !m.wready;   p_wdata  <= m.wdata; p_wlast <= m.wlast;
            p_ar <= m.arvalid && !m.arready; p_araddr <= m.araddr;
        end
    end

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, input logic [3:0] bm,
                               input logic [31:0] s);
        base_addr = b; num_bursts = n; beats_m1 = bm; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/pass/valids/readies=%b expected 00000000",
                     {busy, done, pass, m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready});
        end
        checks++;
        if (err_count !== 16'd0 || first_err_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: err_count=%h first_err_addr=%h expected 0/0", err_count, first_err_addr);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_full_run(input string name, input bit bp_en, input logic [31:0] base);
        int aw0, ar0, w0, st0, at0;
        logic [31:0] exp;
        bp = bp_en; no_rlast = 1'b0; bad_b = -1; bad_raddr = '1;
        aw0 = aw_log.size(); ar0 = ar_log.size(); w0 = w_cnt; st0 = stab_err; at0 = attr_err;
        pulse_start(base, 16'd4, 4'd15, 32'hA5A5_A5A5);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || m.awvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: busy=%b done=%b awvalid=%b expected 1/0/1", name, busy, done, m.awvalid);
        end
        for (int i = 0; i < 5000 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: done=%b pass=%b err_count=%h busy=%b expected 1/1/0000/0",
                     name, done, pass, err_count, busy);
        end
        checks++;
        if (aw_log.size() - aw0 != 4 || ar_log.size() - ar0 != 4 || w_cnt - w0 != 64) begin
            errors++;
            $display("FAIL %s_counts: aw=%0d ar=%0d w=%0d expected 4/4/64", name,
                     aw_log.size() - aw0, ar_log.size() - ar0, w_cnt - w0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp = 32'h8000_0000 + 32'(k * 64);
                checks++;
                if (aw_log[aw0+k] !== exp || ar_log[ar0+k] !== exp ||
                    awlen_log[aw0+k] !== 8'd15 || arlen_log[ar0+k] !== 8'd15) begin
                    errors++;
                    $display("FAIL %s_burst%0d: awaddr=%h araddr=%h awlen=%0d arlen=%0d expected %h len 15",
                             name, k, aw_log[aw0+k], ar_log[ar0+k], awlen_log[aw0+k], arlen_log[ar0+k], exp);
                end
            end
        end
        checks++;
        if (stab_err != st0 || attr_err != at0) begin
            errors++;
            $display("FAIL %s_protocol: stability violations=%0d attribute violations=%0d expected 0/0",
                     name, stab_err - st0, attr_err - at0);
        end
    endtask

    task automatic test_rdata_err();
        bp = 1'b0; no_rlast = 1'b0; bad_b = -1; bad_raddr = 32'h8000_0044;
        pulse_start(32'h8000_0000, 16'd4, 4'd15, 32'hA5A5_A5A5);
        for (int i = 0; i < 5000 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_count !== 16'd1 || first_err_addr !== 32'h8000_0044) begin
            errors++;
            $display("FAIL rdata_err: done=%b pass=%b err_count=%h first_err_addr=%h expected 1/0/0001/80000044",
                     done, pass, err_count, first_err_addr);
        end
        bad_raddr = '1;
    endtask

    task automatic test_bresp_err();
        bp = 1'b0; no_rlast = 1'b0; bad_raddr = '1; bad_b = b_cnt + 2;
        pulse_start(32'h0000_1000, 16'd4, 4'd3, 32'h1234_5678);
        for (int i = 0; i < 5000 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_count !== 16'd1 || first_err_addr !== 32'h0000_1080) begin
            errors++;
            $display("FAIL bresp_err: done=%b pass=%b err_count=%h first_err_addr=%h expected 1/0/0001/00001080",
                     done, pass, err_count, first_err_addr);
        end
        bad_b = -1;
    endtask

    task automatic test_zero();
        int v0;
        bp = 1'b0;
        v0 = vld_cnt;
        pulse_start(32'h8000_0000, 16'd0, 4'd15, 32'h0);
        for (int i = 0; i < 2 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL zero_bursts: done=%b pass=%b busy=%b err_count=%h expected 1/1/0/0000",
                     done, pass, busy, err_count);
        end
        checks++;
        if (vld_cnt != v0) begin
            errors++;
            $display("FAIL zero_traffic: valid cycles=%0d expected 0", vld_cnt - v0);
        end
    endtask

    task automatic test_start_busy();
        int aw0;
        bp = 1'b0; no_rlast = 1'b0; bad_b = -1; bad_raddr = '1;
        aw0 = aw_log.size();
        pulse_start(32'h0000_3000, 16'd1, 4'd0, 32'hDEAD_BEEF);
        pulse_start(32'h0000_4000, 16'd2, 4'd3, 32'h0);
        for (int i = 0; i < 5000 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || aw_log.size() - aw0 != 1 || aw_log[aw0] !== 32'h0000_3000) begin
            errors++;
            $display("FAIL start_busy: done=%b pass=%b aw count=%0d first awaddr=%h expected 1/1/1/00003000",
                     done, pass, aw_log.size() - aw0, aw_log[aw0]);
        end
    endtask

    task automatic test_no_rlast();
        bp = 1'b0; bad_b = -1; bad_raddr = '1; no_rlast = 1'b1;
        pulse_start(32'h0000_2000, 16'd1, 4'd1, 32'h0F0F_0F0F);
        for (int i = 0; i < 5000 && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_count !== 16'd1 || first_err_addr !== 32'h0000_2004) begin
            errors++;
            $display("FAIL no_rlast: done=%b pass=%b err_count=%h first_err_addr=%h expected 1/0/0001/00002004",
                     done, pass, err_count, first_err_addr);
        end
        no_rlast = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w0;
        bp = 1'b0; no_rlast = 1'b0; bad_b = -1; bad_raddr = '1;
        w0 = w_cnt;
        pulse_start(32'h8000_0000, 16'd4, 4'd15, 32'hA5A5_A5A5);
        for (int i = 0; i < 500 && w_cnt - w0 < 5; i++) @(negedge clk);
        checks++;
        if (w_cnt - w0 != 5 || m.wvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_w: w beats=%0d wvalid=%b busy=%b expected 5/1/1", w_cnt - w0, m.wvalid, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready} !== 8'b0 ||
            err_count !== 16'd0 || first_err_addr !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: ctrl=%b err_count=%h first_err_addr=%h expected all 0",
                     {busy, done, pass, m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready},
                     err_count, first_err_addr);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_full_run("after_reset", 1'b0, 32'h8000_0000);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_bursts = '0; beats_m1 = '0; seed = '0;
        test_reset();
        test_full_run("ideal", 1'b0, 32'h8000_0000);
        test_rdata_err();
        test_bresp_err();
        test_full_run("backpressure", 1'b1, 32'h8000_0027);
        test_zero();
        test_start_busy();
        test_no_rlast();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
